wb_reg_file: RTL

//  Write-back-end register file: consumes the MEM/WB pipeline register outputs
//  and commits the result to one of 32 GPRs.

---
 rtl/wb_reg_file_if.sv | 29 ++
 rtl/wb_reg_file.sv | 65 ++++++
 2 files changed

// File: rtl/wb_reg_file_if.sv
// Bus bundle between the MEM/WB stage, the decode read ports and the commit trace.
interface wb_reg_file_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
);
  logic                  RegDest_in;
  logic                  RegWrite_in;
  logic [DATA_W-1:0]     WB_data_in;
  logic [3*ADDR_W-1:0]   rs_rt_rd_in;
  logic [ADDR_W-1:0]     rd_addr1;
  logic [ADDR_W-1:0]     rd_addr2;
  logic [DATA_W-1:0]     rd_data1;
  logic [DATA_W-1:0]     rd_data2;
  logic                  commit_valid;
  logic [ADDR_W-1:0]     commit_addr;
  logic [DATA_W-1:0]     commit_data;
  logic [CNT_W-1:0]      commit_count;

  modport master (
    output RegDest_in, RegWrite_in, WB_data_in, rs_rt_rd_in, rd_addr1, rd_addr2,
    input  rd_data1, rd_data2, commit_valid, commit_addr, commit_data, commit_count
  );

  modport slave (
    input  RegDest_in, RegWrite_in, WB_data_in, rs_rt_rd_in, rd_addr1, rd_addr2,
    output rd_data1, rd_data2, commit_valid, commit_addr, commit_data, commit_count
  );
endinterface

// File: rtl/wb_reg_file.sv
// Write-back register file: 32 GPRs with $zero hardwired, two bypassed read
// ports and a registered commit trace/counter.
module wb_reg_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter bit          BYPASS = 1'b1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic           clk,
  input  logic           reset,
  wb_reg_file_if.slave   bus
);
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] gpr [NUM_REGS];
  logic [ADDR_W-1:0] dest;
  logic              we;
  logic              unusedRs;

  // rs only matters to the read side of the pipeline; writes ignore it
  assign unusedRs = ^bus.rs_rt_rd_in[3*ADDR_W-1:2*ADDR_W];

  assign dest = bus.RegDest_in ? bus.rs_rt_rd_in[ADDR_W-1:0]
                               : bus.rs_rt_rd_in[2*ADDR_W-1:ADDR_W];
  assign we   = bus.RegWrite_in && (dest != '0) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        gpr[i] <= '0;
      end
      bus.commit_valid <= 1'b0;
      bus.commit_addr  <= '0;
      bus.commit_data  <= '0;
      bus.commit_count <= '0;
    end else begin
      bus.commit_valid <= we;
      if (we) begin
        gpr[dest]        <= bus.WB_data_in;
        bus.commit_addr  <= dest;
        bus.commit_data  <= bus.WB_data_in;
        bus.commit_count <= bus.commit_count + CNT_W'(1);
      end
    end
  end

  // Same-cycle write-before-read so ID sees the WB result without a stall
  always_comb begin
    bus.rd_data1 = '0;
    if (BYPASS && we && (dest == bus.rd_addr1)) begin
      bus.rd_data1 = bus.WB_data_in;
    end else if (bus.rd_addr1 != '0) begin
      bus.rd_data1 = gpr[bus.rd_addr1];
    end
  end

  always_comb begin
    bus.rd_data2 = '0;
    if (BYPASS && we && (dest == bus.rd_addr2)) begin
      bus.rd_data2 = bus.WB_data_in;
    end else if (bus.rd_addr2 != '0) begin
      bus.rd_data2 = gpr[bus.rd_addr2];
    end
  end
endmodule
